// File: rtl/prio_encoder_rr_if.sv
// Request/grant bundle for prio_encoder_rr.
//   req_in    : N-bit request pulses into the encoder
//   rr_mode   : 0 = fixed priority, 1 = round-robin
//   out_idx   : granted source index (valid when out_valid=1)
//   out_valid : out_idx holds a granted index
//   out_ready : consumer accepts out_idx this cycle
//   pending   : registered pending-request vector
//   drop      : one-cycle pulse, a request merged into an already-pending bit
// slave modport is the encoder side, master is the source/consumer side.
interface prio_encoder_rr_if #(
  parameter int N = 8
);
  localparam int IDX_W = $clog2(N);

  logic [N-1:0]     req_in;
  logic             rr_mode;
  logic [IDX_W-1:0] out_idx;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     pending;
  logic             drop;

  modport master (
    output req_in, rr_mode, out_ready,
    input  out_idx, out_valid, pending, drop
  );

  modport slave (
    input  req_in, rr_mode, out_ready,
    output out_idx, out_valid, pending, drop
  );
endinterface

// File: rtl/prio_encoder_rr.sv
// Registered priority encoder with fixed-priority / round-robin selection.
// Request pulses are collected in a pending register; each pending bit is
// handed to the consumer once as an index over a valid/ready handshake.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : prio_encoder_rr_if slave modport (req_in, rr_mode, out_ready in;
//         out_idx, out_valid, pending, drop out)
module prio_encoder_rr #(
  parameter  int N     = 8,
  localparam int IDX_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  prio_encoder_rr_if.slave   bus
);

  typedef logic [IDX_W-1:0] idx_t;

  logic [N-1:0] pend_q;
  idx_t         idx_q;
  logic         valid_q;
  logic         drop_q;
  idx_t         rr_ptr;

  logic         load;
  logic         grant;
  idx_t         g_fixed;
  idx_t         g_rr;
  idx_t         g;
  logic         rr_hit;
  logic [N-1:0] clr;
  logic         merge;

  assign load  = ~valid_q | bus.out_ready;
  assign grant = load & (|pend_q);

  // Fixed priority: ascending scan, so the highest set bit is written last.
  always_comb begin
    g_fixed = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pend_q[idx_t'(i)]) g_fixed = idx_t'(i);
    end
  end

  // Round-robin: walk downward from rr_ptr, wrapping from 0 to N-1; the
  // modulo keeps the walk correct when N is not a power of two.
  always_comb begin
    int unsigned j;
    g_rr   = '0;
    rr_hit = 1'b0;
    j      = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(rr_ptr) + N - k) % N;
      if (!rr_hit && pend_q[idx_t'(j)]) begin
        g_rr   = idx_t'(j);
        rr_hit = 1'b1;
      end
    end
  end

  assign g = bus.rr_mode ? g_rr : g_fixed;

  always_comb begin
    clr = '0;
    if (grant) clr[g] = 1'b1;
  end

  // A request on the bit being granted is a fresh request, not a merge.
  assign merge = |(bus.req_in & pend_q & ~clr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
      rr_ptr  <= idx_t'(N - 1);
    end else begin
      pend_q <= (pend_q & ~clr) | bus.req_in;
      drop_q <= merge;
      if (load) begin
        if (grant) begin
          idx_q   <= g;
          valid_q <= 1'b1;
          rr_ptr  <= (g == '0) ? idx_t'(N - 1) : g - 1'b1;
        end else begin
          valid_q <= 1'b0;
        end
      end
    end
  end

  assign bus.out_idx   = idx_q;
  assign bus.out_valid = valid_q;
  assign bus.pending   = pend_q;
  assign bus.drop      = drop_q;

endmodule

// File: doc/prio_encoder_rr.md
Name: prio_encoder_rr

Overview:
- Parametrised, registered successor to the team's 8-input combinational priority encoder.
- Captures request pulses from N sources into a pending register and serves each one exactly once, one index per handshake.
- Selection is either fixed priority (highest index wins) or round-robin, chosen at run time.
- Sits between interrupt/event sources and a downstream consumer that accepts indices through a valid/ready handshake.

Parameters:
- N, 8, number of request inputs; legal values N >= 2.
- IDX_W, $clog2(N), width of the index output; derived, must not be overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_in  input  N  request pulses; bit i high for one cycle means one request from source i.
- rr_mode  input  1  0 = fixed priority, 1 = round-robin; sampled every cycle.
- out_idx  output  IDX_W  index of the granted source; meaningful only when out_valid=1.
- out_valid  output  1  out_idx holds a granted index.
- out_ready  input  1  consumer accepts out_idx this cycle when out_valid=1.
- pending  output  N  registered pending-request vector.
- drop  output  1  one-cycle registered pulse: a request was merged into an already-pending bit.

Behaviour:
- Reset (asynchronous, any time, mid-transfer included) forces:
  - pending=0, out_valid=0, out_idx=0, drop=0.
  - rr_ptr=N-1 (internal start index).
  - Any in-flight index is discarded.
- Load condition: load = ~out_valid | out_ready.
- Selection, from the registered pending vector only (not from req_in in the same cycle):
  - rr_mode=0: the highest set index of pending.
  - rr_mode=1: scan from rr_ptr downward, wrapping N-1 after 0; the first set bit wins.
- On a clock edge with load=1:
  - If pending != 0: out_idx <= selected index g, out_valid <= 1, bit g is cleared from pending, rr_ptr <= (g==0 ? N-1 : g-1).
  - If pending == 0: out_valid <= 0; out_idx and rr_ptr hold.
- On a clock edge with load=0 (out_valid=1, out_ready=0): out_idx, out_valid and rr_ptr hold. This is a stall.
- rr_ptr updates on every grant in both modes. Switching mode takes effect at the next selection.
- Pending update every edge: pending <= (pending & ~clr) | req_in, where clr is the one-hot of g when a grant occurs, else 0.
  - A req_in bit arriving on the same bit being granted stays pending (new request). No drop.
  - A req_in bit arriving on a pending bit that is not being granted is merged. drop <= 1 for one cycle; otherwise drop <= 0.
- Latency: a request sampled at edge k is in pending after edge k. The earliest out_valid with that index is after edge k+1 (two-cycle minimum).
- Throughput: one index per cycle while out_ready=1 and pending != 0.
- Starvation: in fixed mode a continuously re-requesting high index may starve lower indices (by design). In round-robin mode every pending bit is granted within N grants.

Test Plan:
1. Reset: assert rst asynchronously mid-cycle with pending=8'hFF and out_valid=1 -> immediately pending=0, out_valid=0, out_idx=0, drop=0. After release with req_in=0, outputs stay 0.
2. Fixed priority burst: N=8, rr_mode=0, out_ready=1, req_in=8'b1001_0100 for one cycle -> out_idx 7, 4, 2 on three consecutive valid cycles, then out_valid=0 and pending=0.
3. Backpressure: same burst with out_ready=0 for 3 cycles -> out_idx stays 7 with out_valid=1 and pending=8'b0001_0100. Raise out_ready -> 4, then 2.
4. Round-robin vs fixed: req_in=8'b1000_0001 re-pulsed every cycle, out_ready=1.
   - rr_mode=0 -> out_idx 7,7,7,... with drop pulsing (bit 0 merges while pending).
   - rr_mode=1 -> out_idx alternates 7,0,7,0.
5. Drop and same-cycle re-request:
   - Bit 3 pending and not granted, req_in[3]=1 -> drop=1 for exactly one cycle; index 3 is emitted once.
   - req_in[5]=1 in the cycle bit 5 is granted -> no drop; index 5 is emitted a second time later.
6. Wrap-around: rr_mode=1, grant index 0, then pending=8'b1000_0010 -> next grant is 7 (scan wraps from rr_ptr=7), then 1.
